mux_output_checker: RTL and testbench
=====================================

Name: mux_output_checker

Overview:
- Self-checking comparator for the mux testbench.
- Samples the conductual (behavioural) mux outputs and the estructural (synthesized) mux outputs every clock and flags any disagreement.
- Provides per-cycle match flags, a sticky error flag and saturating mismatch counters, so waveforms and console monitors show equivalence at a glance.
- Sits in the probador, fed directly from both mux instances; it drives nothing back into the design.

Parameters:
- DATA_W, 8: width of the compared data buses.
- CNT_W, 16: width of the mismatch and cycle counters.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset_L  input  1  synchronous, active-high reset (reset_L=1 at a rising edge clears state).
- data_out_c  input  DATA_W  data output of the conductual mux.
- data_out_e  input  DATA_W  data output of the estructural mux.
- valid_out_c  input  1  valid output of the conductual mux.
- valid_out_e  input  1  valid output of the estructural mux.
- check_data_out  output  1  registered data-match flag; 1 = match or don't-care.
- check_valid  output  1  registered valid-match flag; 1 = match.
- error_sticky  output  1  set on the first mismatch of either kind; held until reset.
- data_mismatch_cnt  output  CNT_W  number of cycles with a data mismatch.
- valid_mismatch_cnt  output  CNT_W  number of cycles with a valid mismatch.
- first_err_cycle  output  CNT_W  cycle_cnt value at the first mismatch; 0 if none.

Behaviour:
- Reset, synchronous, reset_L=1 at a rising edge:
  - check_data_out=1, check_valid=1, error_sticky=0.
  - Both mismatch counters=0, first_err_cycle=0, internal cycle_cnt=0.
  - Reset overrides all other updates, including a mismatch present in the same cycle.
- Outside reset, each rising edge:
  - cycle_cnt increments, saturating at all-ones.
  - valid_mis = (valid_out_c != valid_out_e).
  - data_mis = (valid_out_c | valid_out_e) & (data_out_c != data_out_e).
  - Data is don't-care when both valids are 0; it is not compared in that case.
  - Any X/Z on a compared bit counts as a mismatch (case-inequality semantics).
  - check_valid <= ~valid_mis; check_data_out <= ~data_mis.
  - Each mismatch counter increments on its mismatch and saturates at all-ones (no wrap).
  - A cycle with both mismatches increments both counters.
  - If error_sticky=0 and (valid_mis | data_mis): error_sticky <= 1 and first_err_cycle <= cycle_cnt.
  - Later mismatches do not change first_err_cycle.
- Latency: exactly one clock from input sample to flag and counter update.
- Outputs are fully registered; there are no combinational input-to-output paths.
- Reset mid-run clears all history. Checking resumes on the first edge after reset is deasserted.

Test Plan:
- Reset held 3 cycles with data_out_c=8'hAA, data_out_e=8'h55 -> all flags stay 1, error_sticky=0, counters 0.
- Identical streams ff, ee, dd, cc with both valids 1 for 4 cycles -> check_data_out=1 and check_valid=1 every cycle, counters 0.
- Both valids 0, data_out_c=8'h33, data_out_e=8'h44 -> check_data_out=1 (don't-care), no count.
- Cycle 5 after reset: valid_out_c=1, valid_out_e=0, data equal -> next cycle check_valid=0, valid_mismatch_cnt=1, error_sticky=1, first_err_cycle=5.
- Both valids 1, data_out_c=8'h88, data_out_e=8'h77 for 2 cycles -> check_data_out=0 twice, data_mismatch_cnt=2, first_err_cycle unchanged.
- Force data_mismatch_cnt to max with CNT_W=4 and 20 mismatching cycles -> counter holds 4'hF.
- Assert reset after mismatches -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/mux_output_checker.sv
// mux_output_checker: registered equivalence checker for the conductual vs estructural mux outputs
//   in : clk, reset_L (sync, active-high), data_out_c/e [DATA_W], valid_out_c/e
//   out: check_data_out, check_valid, error_sticky,
//        data_mismatch_cnt, valid_mismatch_cnt, first_err_cycle [CNT_W]
module mux_output_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_out_c,
    input  logic [DATA_W-1:0] data_out_e,
    input  logic              valid_out_c,
    input  logic              valid_out_e,
    output logic              check_data_out,
    output logic              check_valid,
    output logic              error_sticky,
    output logic [CNT_W-1:0]  data_mismatch_cnt,
    output logic [CNT_W-1:0]  valid_mismatch_cnt,
    output logic [CNT_W-1:0]  first_err_cycle
);
    logic             valid_mis, data_mis;
    logic             check_data_q, check_data_d, check_valid_q, check_valid_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0] valid_cnt_q, valid_cnt_d, first_err_q, first_err_d;
    always_comb begin
        // case-inequality so X/Z on a compared bit counts as a mismatch
        valid_mis     = valid_out_c !== valid_out_e;
        data_mis      = (valid_out_c | valid_out_e) & (data_out_c !== data_out_e);
        check_valid_d = ~valid_mis;
        check_data_d  = ~data_mis;
        cycle_cnt_d   = &cycle_cnt_q ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        data_cnt_d    = (data_mis & ~&data_cnt_q) ? data_cnt_q + 1'b1 : data_cnt_q;
        valid_cnt_d   = (valid_mis & ~&valid_cnt_q) ? valid_cnt_q + 1'b1 : valid_cnt_q;
        error_d       = error_q | valid_mis | data_mis;
        first_err_d   = (~error_q & (valid_mis | data_mis)) ? cycle_cnt_q : first_err_q;
    end
    always_ff @(posedge clk) begin
        if (reset_L) begin
            check_data_q  <= 1'b1;
            check_valid_q <= 1'b1;
            error_q       <= 1'b0;
            cycle_cnt_q   <= '0;
            data_cnt_q    <= '0;
            valid_cnt_q   <= '0;
            first_err_q   <= '0;
        end else begin
            check_data_q  <= check_data_d;
            check_valid_q <= check_valid_d;
            error_q       <= error_d;
            cycle_cnt_q   <= cycle_cnt_d;
            data_cnt_q    <= data_cnt_d;
            valid_cnt_q   <= valid_cnt_d;
            first_err_q   <= first_err_d;
        end
    end
    assign check_data_out     = check_data_q;
    assign check_valid        = check_valid_q;
    assign error_sticky       = error_q;
    assign data_mismatch_cnt  = data_cnt_q;
    assign valid_mismatch_cnt = valid_cnt_q;
    assign first_err_cycle    = first_err_q;
endmodule

// File: tb/tb_mux_output_checker.sv
// tb_mux_output_checker: scoreboard bench for mux_output_checker at CNT_W=16 and CNT_W=4
module tb_mux_output_checker;
    logic       clk = 1'b0;
    logic       reset_L = 1'b1;
    logic [7:0] data_out_c = '0, data_out_e = '0;
    logic       valid_out_c = 1'b0, valid_out_e = 1'b0;
    logic       cd0, cv0, es0, cd1, cv1, es1;
    logic [15:0] dmc0, vmc0, fec0;
    logic [3:0]  dmc1, vmc1, fec1;
    int checks = 0, errors = 0;

    typedef struct {
        bit cd, cv, es;
        int dmc0, vmc0, fec0, dmc1, vmc1, fec1;
    } exp_t;
    exp_t sb[$];

    bit m_cd, m_cv, m_es;
    int m_cyc[2], m_dmc[2], m_vmc[2], m_fec[2];
    int m_max[2] = '{65535, 15};

    always #5 clk = ~clk;

    mux_output_checker #(.DATA_W(8), .CNT_W(16)) dut16 (
        .clk(clk), .reset_L(reset_L), .data_out_c(data_out_c), .data_out_e(data_out_e),
        .valid_out_c(valid_out_c), .valid_out_e(valid_out_e),
        .check_data_out(cd0), .check_valid(cv0), .error_sticky(es0),
        .data_mismatch_cnt(dmc0), .valid_mismatch_cnt(vmc0), .first_err_cycle(fec0));

    mux_output_checker #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset_L(reset_L), .data_out_c(data_out_c), .data_out_e(data_out_e),
        .valid_out_c(valid_out_c), .valid_out_e(valid_out_e),
        .check_data_out(cd1), .check_valid(cv1), .error_sticky(es1),
        .data_mismatch_cnt(dmc1), .valid_mismatch_cnt(vmc1), .first_err_cycle(fec1));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit rst, input logic [7:0] dc, input logic [7:0] de,
                         input logic vc, input logic ve);
        bit vm, dm;
        exp_t e;
        if (rst) begin
            m_cd = 1; m_cv = 1; m_es = 0;
            for (int i = 0; i < 2; i++) begin
                m_cyc[i] = 0; m_dmc[i] = 0; m_vmc[i] = 0; m_fec[i] = 0;
            end
        end else begin
            vm = (vc !== ve);
            dm = (vc || ve) && (dc !== de);
            m_cv = !vm;
            m_cd = !dm;
            for (int i = 0; i < 2; i++) begin
                if (dm && m_dmc[i] < m_max[i]) m_dmc[i]++;
                if (vm && m_vmc[i] < m_max[i]) m_vmc[i]++;
                if (!m_es && (vm || dm)) m_fec[i] = m_cyc[i];
                if (m_cyc[i] < m_max[i]) m_cyc[i]++;
            end
            if (vm || dm) m_es = 1;
        end
        e.cd = m_cd; e.cv = m_cv; e.es = m_es;
        e.dmc0 = m_dmc[0]; e.vmc0 = m_vmc[0]; e.fec0 = m_fec[0];
        e.dmc1 = m_dmc[1]; e.vmc1 = m_vmc[1]; e.fec1 = m_fec[1];
        sb.push_back(e);
    endtask

    task automatic step(input bit rst, input logic [7:0] dc, input logic [7:0] de,
                        input logic vc, input logic ve);
        exp_t e;
        @(negedge clk);
        reset_L = rst; data_out_c = dc; data_out_e = de; valid_out_c = vc; valid_out_e = ve;
        model(rst, dc, de, vc, ve);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("check_data_out", int'(cd0), int'(e.cd));
            check("check_valid", int'(cv0), int'(e.cv));
            check("error_sticky", int'(es0), int'(e.es));
            check("data_mismatch_cnt", int'(dmc0), e.dmc0);
            check("valid_mismatch_cnt", int'(vmc0), e.vmc0);
            check("first_err_cycle", int'(fec0), e.fec0);
            check("check_data_out_w4", int'(cd1), int'(e.cd));
            check("check_valid_w4", int'(cv1), int'(e.cv));
            check("error_sticky_w4", int'(es1), int'(e.es));
            check("data_mismatch_cnt_w4", int'(dmc1), e.dmc1);
            check("valid_mismatch_cnt_w4", int'(vmc1), e.vmc1);
            check("first_err_cycle_w4", int'(fec1), e.fec1);
        end
    endtask

    initial begin
        logic [7:0] a, b;
        for (int i = 0; i < 3; i++) step(1, 8'hAA, 8'h55, 1, 0);
        check("reset_hold_cd", int'(cd0), 1);
        check("reset_hold_es", int'(es0), 0);
        step(0, 8'hFF, 8'hFF, 1, 1);
        step(0, 8'hEE, 8'hEE, 1, 1);
        step(0, 8'hDD, 8'hDD, 1, 1);
        step(0, 8'hCC, 8'hCC, 1, 1);
        step(0, 8'h33, 8'h44, 0, 0);
        check("dont_care_cd", int'(cd0), 1);
        step(0, 8'h12, 8'h12, 1, 0);
        check("first_err_5", int'(fec0), 5);
        check("valid_cnt_1", int'(vmc0), 1);
        step(0, 8'h88, 8'h77, 1, 1);
        step(0, 8'h88, 8'h77, 1, 1);
        check("data_cnt_2", int'(dmc0), 2);
        check("first_err_kept", int'(fec0), 5);
        step(0, 8'h01, 8'h02, 0, 1);
        check("both_data_cnt", int'(dmc0), 3);
        check("both_valid_cnt", int'(vmc0), 2);
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = a ^ 8'(1 + $urandom_range(0, 254));
            step(0, a, b, 1, 1);
        end
        check("sat_w4", int'(dmc1), 15);
        check("no_sat_w16", int'(dmc0), 23);
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
            step(0, a, b, 1'($urandom), 1'($urandom));
        end
        step(1, 8'h88, 8'h77, 1, 0);
        check("mid_reset_cnt", int'(dmc0), 0);
        check("mid_reset_es", int'(es0), 0);
        check("mid_reset_fec", int'(fec0), 0);
        step(0, 8'h10, 8'h10, 1, 1);
        step(0, 8'h10, 8'h10, 1, 1);
        step(0, 8'h10, 8'h11, 1, 1);
        check("restart_fec_2", int'(fec0), 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
